// File: rtl/filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// filter_frame_ctrl
//
// Frame sequencer for the `filter` datapath. Accepts one frame of samples over
// a valid/ready stream, gates the filter's clock enable, flushes the filter
// pipeline with zero samples at the end of the frame, and presents exactly
// frame_len results over a valid/ready output stream.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          frame start request (IDLE only) / synchronous abort
//   frame_len             samples per frame, captured on an accepted start
//   in_valid/in_ready     input sample handshake, in_data carries the sample
//   filt_clk_enable       to filter.clk_enable
//   filt_input            to filter.input_rsvd
//   filt_output           from filter.output_rsvd
//   out_valid/out_ready   output result handshake, out_data = filt_output
//   busy                  controller is not IDLE
//   done                  one-cycle pulse after the final output handshake
// -----------------------------------------------------------------------------
module filter_frame_ctrl #(
    parameter int DATA_W  = 10,
    parameter int CNT_W   = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              filt_clk_enable,
    output logic [DATA_W-1:0] filt_input,
    input  logic [DATA_W-1:0] filt_output,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The enable counter gets one extra bit: a maximum-length frame plus the
    // flush enables would otherwise wrap.
    localparam int             EW    = CNT_W + 1;
    localparam logic [EW-1:0]  LAT_C = EW'(LATENCY);
    localparam logic [EW-1:0]  ONE_E = EW'(1'b1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [EW-1:0]      en_cnt_q, en_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_valid_q, out_valid_d;

    logic               stall_s;
    logic               hs_s;
    logic               enable_s;
    logic [EW-1:0]      en_next_s;
    logic [EW-1:0]      len_ext_s;

    // Handshake / enable decode shared by outputs and next-state logic.
    always_comb begin
        stall_s   = out_valid_q & ~out_ready;
        hs_s      = out_valid_q & out_ready;
        en_next_s = en_cnt_q + ONE_E;
        len_ext_s = {1'b0, len_q};
        case (state_q)
            ST_RUN:   enable_s = in_valid & ~stall_s;
            ST_FLUSH: enable_s = ~stall_s;
            default:  enable_s = 1'b0;
        endcase
    end

    // Stream-facing outputs; the filter only advances while nothing is stalled,
    // so filt_output (and thus out_data) is stable during a stall.
    always_comb begin
        in_ready        = (state_q == ST_RUN) & ~stall_s;
        filt_clk_enable = enable_s;
        if (state_q == ST_RUN) begin
            filt_input = in_data;
        end else begin
            filt_input = {DATA_W{1'b0}};
        end
        out_valid = out_valid_q;
        out_data  = filt_output;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    // Next-state, counter and output-valid computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        en_cnt_d    = en_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        if (enable_s) begin
            en_cnt_d = en_next_s;
        end else begin
            en_cnt_d = en_cnt_q;
        end

        if (hs_s) begin
            out_cnt_d = out_cnt_q + CNT_W'(1'b1);
        end else begin
            out_cnt_d = out_cnt_q;
        end

        // Enabled edge number e yields result (e - LATENCY) once the pipe is
        // full; a simultaneous handshake keeps valid high for full throughput.
        if (enable_s && (en_next_s >= LAT_C) && ((en_next_s - LAT_C) < len_ext_s)) begin
            out_valid_d = 1'b1;
        end else if (hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = frame_len;
                    en_cnt_d    = {EW{1'b0}};
                    out_cnt_d   = {CNT_W{1'b0}};
                    out_valid_d = 1'b0;
                    if (frame_len != {CNT_W{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable_s && (en_next_s == len_ext_s)) begin
                    state_d = (LATENCY > 1) ? ST_FLUSH : ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (enable_s && (en_next_s == (len_ext_s + LAT_C - ONE_E))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // Looking at the post-handshake count makes done follow the
                // last handshake by exactly one cycle.
                if (out_cnt_d == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in IDLE.
        if (abort) begin
            state_d     = ST_IDLE;
            len_d       = {CNT_W{1'b0}};
            en_cnt_d    = {EW{1'b0}};
            out_cnt_d   = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= {CNT_W{1'b0}};
            en_cnt_q    <= {EW{1'b0}};
            out_cnt_q   <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            en_cnt_q    <= en_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_frame_ctrl
//
// Bench for filter_frame_ctrl. Two controller instances (LATENCY 1 and 3) each
// drive a behavioural filter that is a pure LATENCY-stage delay line, so every
// result must equal the accepted sample it belongs to, in input order.
// -----------------------------------------------------------------------------
module tb_filter_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] frame_len;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        out_ready;
    logic        sel;

    logic        start0, start1;
    logic        ir0, ir1, en0, en1, ov0, ov1, busy0, busy1, done0, done1;
    logic [9:0]  fi0, fi1, fo0, fo1, od0, od1;

    logic        s_in_ready, s_en, s_ov, s_busy, s_done;
    logic [9:0]  s_finp, s_od;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    filter_frame_ctrl #(.DATA_W(10), .CNT_W(16), .LATENCY(1)) u_dut0 (
        .clk(clk), .reset(rst), .start(start0), .abort(abort), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
        .filt_clk_enable(en0), .filt_input(fi0), .filt_output(fo0),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .busy(busy0), .done(done0)
    );

    filter_frame_ctrl #(.DATA_W(10), .CNT_W(16), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .abort(abort), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
        .filt_clk_enable(en1), .filt_input(fi1), .filt_output(fo1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .busy(busy1), .done(done1)
    );

    // Filter models: enabled delay lines of depth LATENCY.
    logic [9:0] p0;
    logic [9:0] p1 [3];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= 10'd0;
        end else if (en0) begin
            p0 <= fi0;
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1[0] <= 10'd0; p1[1] <= 10'd0; p1[2] <= 10'd0;
        end else if (en1) begin
            p1[0] <= fi1; p1[1] <= p1[0]; p1[2] <= p1[1];
        end
    end
    assign fo0 = p0;
    assign fo1 = p1[2];

    assign s_in_ready = sel ? ir1   : ir0;
    assign s_en       = sel ? en1   : en0;
    assign s_ov       = sel ? ov1   : ov0;
    assign s_busy     = sel ? busy1 : busy0;
    assign s_done     = sel ? done1 : done0;
    assign s_finp     = sel ? fi1   : fi0;
    assign s_od       = sel ? od1   : od0;

    task automatic check(input logic ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        vsel;
        int          len;
        logic [15:0] vmask;
        logic [15:0] rmask;
        int          exp_out;
        int          exp_en;
        int          exp_zero;
    } vec_t;

    // Runs one frame on the selected instance and scores it against the model.
    task automatic run_frame(input logic vsel, input int len, input logic [15:0] vmask,
                             input logic [15:0] rmask, input int exp_out, input int exp_en,
                             input int exp_zero);
        int cyc, n_acc, n_en, n_zero, n_out, last_hs, done_cyc, budget, k;
        logic stall, prev_stall, seen_done, finished;
        logic [9:0] prev_od, exp_d;
        logic [9:0] q[$];
        sel = vsel;
        budget = len * 4 + 64;
        cyc = 0; n_acc = 0; n_en = 0; n_zero = 0; n_out = 0;
        last_hs = 0; done_cyc = -1; prev_stall = 1'b0; prev_od = 10'd0;
        seen_done = 1'b0; finished = 1'b0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            k = (cyc - 1) & 15;
            start     = (cyc == 0);
            frame_len = 16'(len);
            if (cyc == 0) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                in_valid = vmask[k]; out_ready = rmask[k];
            end
            in_data = 10'(n_acc * 37 + 13 + len);
            #1;
            if (seen_done) begin
                check(!s_busy, "busy_after_done", s_busy, 0);
                check(!s_done, "done_one_cycle", s_done, 0);
                finished = 1'b1;
            end else begin
                stall = s_ov & ~out_ready;
                check(!(s_en && stall), "no_enable_in_stall", s_en, 0);
                if (prev_stall) check(s_od == prev_od, "out_data_stable", s_od, prev_od);
                if (s_in_ready) check(s_en == in_valid, "enable_eq_in_valid", s_en, in_valid);
                if (s_en) begin
                    n_en++;
                    if (!s_in_ready) begin
                        n_zero++;
                        check(s_finp == 10'd0, "flush_input_zero", s_finp, 0);
                    end
                end
                if (s_in_ready && in_valid) begin
                    q.push_back(in_data);
                    n_acc++;
                end
                if (s_ov && out_ready) begin
                    if (q.size() == 0) begin
                        check(1'b0, "output_without_input", n_out, -1);
                    end else begin
                        exp_d = q.pop_front();
                        check(s_od == exp_d, "out_data", s_od, exp_d);
                    end
                    n_out++;
                    last_hs = cyc;
                end
                if (s_done) begin
                    seen_done = 1'b1;
                    done_cyc  = cyc;
                end
                prev_stall = stall;
                prev_od    = s_od;
            end
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
        check(finished, "frame_completed", finished, 1);
        check(n_acc == len, "accepts", n_acc, len);
        check(n_out == exp_out, "outputs", n_out, exp_out);
        check(n_en == exp_en, "enables", n_en, exp_en);
        check(n_zero == exp_zero, "zero_enables", n_zero, exp_zero);
        check(done_cyc == last_hs + 1, "done_timing", done_cyc, last_hs + 1);
    endtask

    vec_t vecs [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, guard;
        logic found;

        vecs[0] = '{1'b0, 2000, 16'hFFFF, 16'hFFFF, 2000, 2000, 0}; // streaming, LAT 1
        vecs[1] = '{1'b1, 8,    16'hFFFF, 16'h5555, 8,    10,   2}; // backpressure, LAT 3
        vecs[2] = '{1'b0, 4,    16'h0059, 16'hFFFF, 4,    4,    0}; // input gaps 1,0,0,1,1,0,1
        vecs[3] = '{1'b1, 0,    16'hFFFF, 16'hFFFF, 0,    0,    0}; // zero length, LAT 3
        vecs[4] = '{1'b0, 0,    16'hFFFF, 16'hFFFF, 0,    0,    0}; // zero length, LAT 1
        vecs[5] = '{1'b0, 5,    16'hAAAA, 16'h3333, 5,    5,    0};
        vecs[6] = '{1'b1, 1,    16'hFFFF, 16'hFFFF, 1,    3,    2};
        vecs[7] = '{1'b1, 6,    16'h6DB6, 16'h0F0F, 6,    8,    2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = 16'd0;
        in_valid = 1'b0; in_data = 10'd0; out_ready = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check({ir0, en0, ov0, busy0, done0} == 5'b0, "reset_outputs_lat1", {ir0, en0, ov0, busy0, done0}, 0);
        check({ir1, en1, ov1, busy1, done1} == 5'b0, "reset_outputs_lat3", {ir1, en1, ov1, busy1, done1}, 0);
        check(fi0 == 10'd0 && fi1 == 10'd0, "reset_filt_input", fi1, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].vsel, vecs[i].len, vecs[i].vmask, vecs[i].rmask,
                      vecs[i].exp_out, vecs[i].exp_en, vecs[i].exp_zero);
        end

        // Abort after 5 of 10 samples on the LATENCY 3 instance.
        sel = 1'b1;
        @(negedge clk);
        start = 1'b1; frame_len = 16'd10; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        acc = 0; guard = 0;
        while (acc < 5 && guard < 20) begin
            in_valid = 1'b1;
            in_data  = 10'(acc + 200);
            #1;
            if (s_in_ready) acc++;
            guard++;
            @(negedge clk);
        end
        check(acc == 5, "abort_prefill_accepts", acc, 5);
        in_valid = 1'b0; abort = 1'b1; start = 1'b1; frame_len = 16'd2;
        @(posedge clk);
        #1;
        check(!s_busy, "abort_idle", s_busy, 0);
        check(!s_ov, "abort_out_valid", s_ov, 0);
        check(!s_in_ready, "abort_in_ready", s_in_ready, 0);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check(!s_done && !s_busy, "abort_no_done", s_done, 0);
            @(negedge clk);
        end
        // Abort wins over a simultaneous start in IDLE.
        abort = 1'b1; start = 1'b1; frame_len = 16'd3;
        @(posedge clk);
        #1;
        check(!s_busy, "abort_beats_start", s_busy, 0);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        run_frame(1'b1, 3, 16'hFFFF, 16'hFFFF, 3, 5, 2);

        // Asynchronous reset in the middle of FLUSH.
        sel = 1'b1;
        @(negedge clk);
        start = 1'b1; frame_len = 16'd2; in_valid = 1'b1; out_ready = 1'b1; in_data = 10'd77;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0; guard = 0;
        while (!found && guard < 10) begin
            #1;
            if (s_busy && !s_in_ready && s_en) found = 1'b1;
            else @(negedge clk);
            guard++;
        end
        check(found, "reached_flush", found, 1);
        #1;
        rst = 1'b1;
        #1;
        check({ir1, en1, ov1, busy1, done1} == 5'b0, "async_reset_outputs",
              {ir1, en1, ov1, busy1, done1}, 0);
        check(fi1 == 10'd0, "async_reset_filt_input", fi1, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check(!busy1, "start_ignored_in_reset", busy1, 0);
        @(negedge clk);
        start = 1'b0; rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check(!busy1, "idle_after_reset", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
Sequences the `filter` datapath for one frame of sfix10_En3 samples at a time. It accepts samples over a valid/ready input stream, drives the filter's `clk_enable` and `input_rsvd`, and tracks pipeline fill. When the frame ends, it flushes the pipeline with zeros and delivers exactly `frame_len` outputs over a valid/ready output stream. It sits between the sample source/sink and the `u_filter` instance, and replaces the open-loop enable generation used in bench-only flows.

Parameters:
- `DATA_W`, 10, sample width (sfix10_En3, passed through unmodified).
- `CNT_W`, 16, width of the frame-length and all internal counters.
- `LATENCY`, 1, number of enabled filter clock edges from presenting a sample to its result appearing on `filt_output` (legal range 1..15).

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle frame start request; sampled only in IDLE.
- `abort`, input, 1: synchronous abort; returns to IDLE.
- `frame_len`, input, CNT_W: number of samples in the frame; captured on an accepted `start`.
- `in_valid`, input, 1: input sample valid.
- `in_data`, input, DATA_W: input sample.
- `in_ready`, output, 1: controller accepts `in_data` this cycle.
- `filt_clk_enable`, output, 1: to `filter.clk_enable`.
- `filt_input`, output, DATA_W: to `filter.input_rsvd`.
- `filt_output`, input, DATA_W: from `filter.output_rsvd`.
- `out_valid`, output, 1: `out_data` holds a frame result.
- `out_data`, output, DATA_W: result sample; combinational copy of `filt_output`.
- `out_ready`, input, 1: sink accepts `out_data`.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when the last output handshake completes.

Behaviour:
- Clock and reset: one clock (`clk`). `reset` is asynchronous and active-high.
- Reset values: state IDLE; all counters 0; `out_valid`, `in_ready`, `filt_clk_enable`, `busy` and `done` all 0; `filt_input` 0.
- States:
  - IDLE: on `start`, capture `frame_len` into `len_q` and clear counters. Go to RUN if `frame_len` != 0, otherwise go to DONE.
  - RUN: accept samples. Go to FLUSH after the `len_q`-th accept.
  - FLUSH: issue `LATENCY-1` zero-sample enables. When `LATENCY`=1, skip FLUSH and go directly to DRAIN.
  - DRAIN: wait until `out_cnt` == `len_q`.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Stall condition: `stall` = `out_valid` & ~`out_ready`.
- RUN enable and handshake:
  - `in_ready` = (state==RUN) & ~`stall`.
  - `filt_clk_enable` = `in_valid` & `in_ready`.
  - `filt_input` = `in_data`.
- FLUSH enable: `filt_clk_enable` = ~`stall`, with `filt_input` = 0.
- No enables are issued in IDLE, DRAIN or DONE, so the filter holds its state.
- `en_cnt`: increments on each enabled edge.
- Output valid generation:
  - After an enabled edge bringing `en_cnt` to e, `out_valid` is set if e ≥ `LATENCY` and (e − `LATENCY`) < `len_q`.
  - Otherwise, `out_valid` is cleared when `out_valid` & `out_ready`.
  - A handshake and a new enabled edge in the same cycle keep `out_valid` high, so back-to-back throughput is 1 sample per clock.
- `out_cnt`: increments on each `out_valid` & `out_ready`.
- Total enables per frame = `len_q` + `LATENCY` − 1. Exactly `len_q` outputs are presented, in input order.
- `done` timing: pulses the cycle after the final output handshake. For `frame_len`=0, it pulses the cycle after `start`.
- `start` outside IDLE: ignored, with no effect on the current frame.
- `abort` (any state): next cycle is IDLE, counters are cleared and `out_valid` is 0. `done` does not pulse. The filter's internal state is not cleared; the next frame inherits history.
- `abort` together with `start` in IDLE: `abort` wins.
- `reset` mid-frame: immediate return to reset values; the filter receives the same `reset`.
- Counter arithmetic: unsigned CNT_W. `frame_len` max = 2^CNT_W − 1, and `en_cnt` does not wrap within a legal frame.
- `out_data` is never registered in the controller. Data stability under stall is guaranteed because `filt_clk_enable` stays low while `stall` is high.

Test Plan:
- Streaming: `frame_len`=2000, `LATENCY`=1, `in_valid` and `out_ready` held high → 2000 enables, 2000 outputs matching `output_rsvd_expected.dat` in order, `done` 1 cycle after the last output, `busy` low after.
- Backpressure: `frame_len`=8, `LATENCY`=3, `out_ready` toggling 1010… → `filt_clk_enable` never high while `stall`=1, `out_data` stable during stall, exactly 8 outputs, 10 enables total (last 2 with `filt_input`=0).
- Input gaps: `frame_len`=4, `in_valid` pattern 1,0,0,1,1,0,1 → exactly 4 enables, each coincident with `in_valid`; no enable while `in_valid`=0 in RUN.
- Zero-length frame: `frame_len`=0, `start` pulse → `in_ready` never high, no enables, `done` pulse 1 cycle after `start`.
- Abort: abort after 5 of 10 samples → IDLE next cycle, `out_valid`=0, no `done` pulse; a new `start` with `frame_len`=3 completes with 3 outputs.
- Asynchronous reset: assert `reset` mid-FLUSH between clock edges → all outputs go to 0 immediately; `start` ignored until `reset` deasserts.
